// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: steps IF/ID/EX/MEM/WB over a shared
// memory and ALU, drives all datapath selects/enables, halts on ecall with x17==10.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 7,
    parameter int STATE_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                bcond,
    input  logic                is_x17_ten,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                pc_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                inst_retired,
    output logic                illegal_inst,
    output logic                is_halted
);
    typedef enum logic [STATE_W-1:0] {
        S_IF   = STATE_W'(0),
        S_ID   = STATE_W'(1),
        S_EX   = STATE_W'(2),
        S_MEM  = STATE_W'(3),
        S_WB   = STATE_W'(4),
        S_HALT = STATE_W'(5)
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_ECALL  = OPCODE_W'(7'b1110011);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   known_op;

    assign known_op = (opcode == OP_R)      || (opcode == OP_I)     ||
                      (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                      (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                      (opcode == OP_JALR)   || (opcode == OP_ECALL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        pc_to_reg    = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = 2'd0;
        pc_source    = 2'd0;
        inst_retired = 1'b0;
        is_halted    = 1'b0;
        illegal_inst = illegal_q;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                // PC + imm lands in ALUOut for later branch/JAL use
                alu_src_b = 2'd2;
                if (opcode == OP_ECALL) begin
                    state_d = is_x17_ten ? S_HALT : S_WB;
                end else if (!known_op) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = S_WB;
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'd2;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        alu_op    = 2'd2;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a    = 1'b1;
                        alu_op       = 2'd1;
                        pc_write     = 1'b1;
                        pc_source    = bcond ? 2'd1 : 2'd0;
                        inst_retired = 1'b1;
                        state_d      = S_IF;
                    end
                    OP_JAL: ;
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        mem_read = 1'b1;
                        if (mem_ready) state_d = S_WB;
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            pc_write     = 1'b1;
                            inst_retired = 1'b1;
                            state_d      = S_IF;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                inst_retired = 1'b1;
                state_d      = S_IF;
                case (opcode)
                    OP_R, OP_I: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OP_LOAD: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 1'b1;
                        pc_write   = 1'b1;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'd1;
                    end
                    // PC was already redirected in EX
                    OP_JALR: begin
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                    end
                    OP_ECALL: pc_write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: is_halted = 1'b1;
            default: state_d = S_IF;
        endcase

        // Reset kills every output combinationally, even mid-transaction
        if (!reset) begin
            {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, pc_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, inst_retired,
             illegal_inst, is_halted} = '0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-route reference model
// predicts every control output each cycle, plus directed latency/halt/reset cases.
module tb_multicycle_control_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic       bcond = 1'b0;
    logic       is_x17_ten = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, pc_to_reg;
    logic       reg_write, alu_src_a, inst_retired, illegal_inst, is_halted;
    logic [1:0] alu_src_b, alu_op, pc_source;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .is_x17_ten(is_x17_ten), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .pc_to_reg(pc_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .inst_retired(inst_retired), .illegal_inst(illegal_inst), .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, pc_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       inst_retired, illegal_inst, is_halted;
    } ctl_t;

    ctl_t dut_v;
    assign dut_v = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, pc_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                    inst_retired, illegal_inst, is_halted};

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_ECALL = 7'b1110011, OPC_BAD = 7'b1111111;

    // Model steps: Fetch, Decode, Execute, Memory, Writeback, Halted
    localparam int F = 0, D = 1, E = 2, M = 3, W = 4, H = 5;
    int cur = F;
    int rest[$];
    bit m_ill = 1'b0;
    int n_cmp = 0, n_err = 0;
    logic [6:0] ops [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_known(input logic [6:0] op);
        return op inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_ECALL};
    endfunction

    function automatic ctl_t expect_ctl(input int st, input logic [6:0] op, input logic bc,
                                        input logic mr);
        ctl_t c = '0;
        case (st)
            F: begin c.mem_read = 1'b1; c.ir_write = mr; end
            D: c.alu_src_b = 2'd2;
            E: begin
                if (op == OPC_R) begin c.alu_src_a = 1; c.alu_op = 2; end
                if (op == OPC_I) begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 2; end
                if (op == OPC_LD || op == OPC_ST) begin c.alu_src_a = 1; c.alu_src_b = 2; end
                if (op == OPC_BR) begin
                    c.alu_src_a = 1; c.alu_op = 1; c.pc_write = 1; c.inst_retired = 1;
                    c.pc_source = bc ? 2'd1 : 2'd0;
                end
                if (op == OPC_JALR) begin
                    c.alu_src_a = 1; c.alu_src_b = 2; c.pc_write = 1; c.pc_source = 2;
                end
            end
            M: begin
                c.i_or_d = 1'b1;
                if (op == OPC_LD) c.mem_read = 1'b1;
                if (op == OPC_ST) begin
                    c.mem_write = 1'b1;
                    c.pc_write = mr;
                    c.inst_retired = mr;
                end
            end
            W: begin
                c.inst_retired = 1'b1;
                if (op == OPC_R || op == OPC_I) begin c.reg_write = 1; c.pc_write = 1; end
                if (op == OPC_LD) begin c.reg_write = 1; c.mem_to_reg = 1; c.pc_write = 1; end
                if (op == OPC_JAL) begin
                    c.reg_write = 1; c.pc_to_reg = 1; c.pc_write = 1; c.pc_source = 1;
                end
                if (op == OPC_JALR) begin c.reg_write = 1; c.pc_to_reg = 1; end
                if (op == OPC_ECALL) c.pc_write = 1'b1;
            end
            H: c.is_halted = 1'b1;
            default: ;
        endcase
        c.illegal_inst = m_ill;
        return c;
    endfunction

    // Decode picks the remaining route of the instruction; later steps just pop it
    function automatic void model_step();
        case (cur)
            F: if (mem_ready) cur = D;
            D: begin
                rest.delete();
                if (opcode == OPC_ECALL) cur = is_x17_ten ? H : W;
                else if (!is_known(opcode)) begin m_ill = 1'b1; cur = H; end
                else begin
                    if (opcode == OPC_LD) begin rest.push_back(M); rest.push_back(W); end
                    else if (opcode == OPC_ST) rest.push_back(M);
                    else if (opcode != OPC_BR) rest.push_back(W);
                    cur = E;
                end
            end
            E, W: cur = (rest.size() != 0) ? rest.pop_front() : F;
            M: if (mem_ready) cur = (rest.size() != 0) ? rest.pop_front() : F;
            default: ;
        endcase
    endfunction

    task automatic cyc(input string tag);
        ctl_t e;
        @(negedge clk);
        e = expect_ctl(cur, opcode, bcond, mem_ready);
        chk($sformatf("%s step%0d op%b", tag, cur, opcode), 32'(dut_v), 32'(e));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        cur = F;
        rest.delete();
        m_ill = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_zero", 32'(dut_v), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic run_inst(input logic [6:0] op, input logic x17, input logic bc,
                            input int stalls, input bit rnd, output int n);
        bit left = 1'b0;
        int ms = 0;
        n = 0;
        opcode = op;
        is_x17_ten = x17;
        bcond = bc;
        while (1) begin
            if (rnd) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                bcond = 1'($urandom_range(0, 1));
            end else begin
                mem_ready = !(cur == M && ms < stalls);
                if (!mem_ready) ms++;
            end
            cyc("inst");
            n++;
            if (cur != F) left = 1'b1;
            if ((left && cur == F) || cur == H) break;
            if (n >= 200) begin
                chk("timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic halt_hold(input int k);
        repeat (k) begin
            opcode = 7'($urandom_range(0, 127));
            mem_ready = 1'($urandom_range(0, 1));
            bcond = 1'($urandom_range(0, 1));
            is_x17_ten = 1'($urandom_range(0, 1));
            cyc("halt");
        end
    endtask

    initial begin
        int n;
        int r;
        logic [6:0] op;
        ops = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_ECALL};

        do_reset(3);
        run_inst(OPC_R,    0, 0, 0, 0, n); chk("r_cycles", 32'(n), 32'd4);
        run_inst(OPC_LD,   0, 0, 2, 0, n); chk("ld_stall_cycles", 32'(n), 32'd7);
        run_inst(OPC_BR,   0, 1, 0, 0, n); chk("br_taken_cycles", 32'(n), 32'd3);
        run_inst(OPC_BR,   0, 0, 0, 0, n); chk("br_not_cycles", 32'(n), 32'd3);
        run_inst(OPC_JALR, 0, 0, 0, 0, n); chk("jalr_cycles", 32'(n), 32'd4);
        run_inst(OPC_JAL,  0, 0, 0, 0, n); chk("jal_cycles", 32'(n), 32'd4);
        run_inst(OPC_I,    0, 0, 0, 0, n); chk("i_cycles", 32'(n), 32'd4);
        run_inst(OPC_ST,   0, 0, 1, 0, n); chk("st_stall_cycles", 32'(n), 32'd5);
        run_inst(OPC_ECALL, 0, 0, 0, 0, n); chk("ecall_nop_cycles", 32'(n), 32'd3);

        run_inst(OPC_ECALL, 1, 0, 0, 0, n); chk("ecall_halt_cycles", 32'(n), 32'd2);
        halt_hold(20);
        do_reset(2);
        run_inst(OPC_BAD, 0, 0, 0, 0, n); chk("illegal_cycles", 32'(n), 32'd2);
        halt_hold(3);
        do_reset(2);

        // Async reset in the middle of a stalled store
        opcode = OPC_ST;
        mem_ready = 1'b1;
        repeat (3) cyc("st_pre");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("st_mem_write", 32'(mem_write), 32'd1);
        #1 reset = 1'b0;
        #1 chk("async_rst_zero", 32'(dut_v), 32'd0);
        do_reset(2);
        run_inst(OPC_R, 0, 0, 0, 0, n); chk("restart_cycles", 32'(n), 32'd4);

        repeat (300) begin
            r = $urandom_range(0, 39);
            op = (r == 0) ? OPC_BAD : ops[r % 8];
            run_inst(op, ($urandom_range(0, 3) == 0), 0, 0, 1, n);
            if (cur == H) begin
                halt_hold(5);
                do_reset(2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
